// File: rtl/mdu_if.sv
// mdu_if: handshake and result bus between the MIPS control/datapath and the
// iterative multiply/divide unit.
//   start  issue request (sampled on the rising clock edge)
//   op     operation code: 000 mult, 001 multu, 010 div, 011 divu,
//          100 mthi, 101 mtlo, 11x reserved
//   a, b   GPR rs / rt operands
//   busy   multiply/divide in progress (stall request)
//   hi, lo HI/LO result registers
// Modports: master drives the request side, slave is the unit itself.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit holding the HI/LO registers.
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high clear of all state
//   bus    mdu_if slave: start/op/a/b in, busy/hi/lo out
// Multiply is radix-2 shift-add, divide is restoring shift-subtract, both on
// operand magnitudes with a sign fixup applied on the last iteration edge.
// busy is high for exactly WIDTH cycles; hi/lo change only on the final edge
// (or immediately for mthi/mtlo).
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Magnitude of v when treated as signed, raw v otherwise.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    mag = (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  logic [0:0]         state_r;
  logic               busy_r;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic               neg_lo_r;     // product sign / quotient sign
  logic               neg_hi_r;     // remainder sign (follows dividend)
  logic               div_zero_r;
  logic [WIDTH-1:0]   a_raw_r;      // raw dividend bits for the divide-by-zero result
  logic [WIDTH-1:0]   opnd_r;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_r;        // {upper, lower}: product or {remainder, quotient}
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               is_signed_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;

  // Issue-time operand conditioning: op[0] clear selects the signed variants.
  always_comb begin
    is_signed_s = ~bus.op[0];
    a_mag_s     = mag(bus.a, is_signed_s);
    b_mag_s     = mag(bus.b, is_signed_s);
  end

  // One iteration step plus the sign-fixed final result built from that step.
  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    add_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
              (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the WIDTH+1 bit partial
    // remainder and trial-subtract the divisor; a set MSB means borrow.
    shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    diff_s  = shift_s - {1'b0, opnd_r};

    if (is_div_r) begin
      if (diff_s[WIDTH]) begin
        acc_next_s = {shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next_s = {add_s, acc_r[WIDTH-1:1]};
    end

    prod_s = neg_lo_r ? -acc_next_s : acc_next_s;
    quo_s  = acc_next_s[WIDTH-1:0];
    rem_s  = acc_next_s[2*WIDTH-1:WIDTH];

    if (!is_div_r) begin
      fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_s[WIDTH-1:0];
    end else if (div_zero_r) begin
      fin_hi_s = a_raw_r;
      fin_lo_s = {WIDTH{1'b1}};
    end else begin
      fin_hi_s = neg_hi_r ? -rem_s : rem_s;
      fin_lo_s = neg_lo_r ? -quo_s : quo_s;
    end
  end

  // FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      is_div_r   <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_hi_r   <= 1'b0;
      div_zero_r <= 1'b0;
      a_raw_r    <= {WIDTH{1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_r    <= RUN;
                busy_r     <= 1'b1;
                cnt_r      <= CW'(WIDTH);
                is_div_r   <= bus.op[1];
                neg_lo_r   <= is_signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_hi_r   <= is_signed_s & bus.a[WIDTH-1];
                div_zero_r <= (bus.b == {WIDTH{1'b0}});
                a_raw_r    <= bus.a;
                if (bus.op[1]) begin
                  opnd_r <= b_mag_s;
                  acc_r  <= {{WIDTH{1'b0}}, a_mag_s};
                end else begin
                  opnd_r <= a_mag_s;
                  acc_r  <= {{WIDTH{1'b0}}, b_mag_s};
                end
              end
              OP_MTHI: hi_r <= bus.a;
              OP_MTLO: lo_r <= bus.a;
              default: begin
                // reserved op codes leave all state untouched
              end
            endcase
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            hi_r    <= fin_hi_s;
            lo_r    <= fin_lo_s;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
